sram22_pmodel: RTL and testbench

SRAM22_PMODEL -- requirements
Module: sram22_pmodel

---
 rtl/sram22_pmodel_if.sv | 26 ++
 rtl/sram22_pmodel.sv | 104 ++++++++++
 tb/tb_sram22_pmodel.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sram22_pmodel_if.sv
// Access bus of the sram22 behavioural model: request fields from the master,
// registered read data and status back from the memory.
interface sram22_pmodel_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 4
);
    logic                   ce;
    logic                   we;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  din;
    logic [DATA_WIDTH-1:0]  dout;
    logic                   dout_valid;
    logic                   busy;

    modport master (
        output ce, we, wmask, addr, din,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  ce, we, wmask, addr, din,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/sram22_pmodel.sv
// Single-port SRAM model with per-lane write mask, one-cycle registered read
// and an optional zero-fill sweep after every reset.
module sram22_pmodel #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int WMASK_WIDTH    = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rstb,
    sram22_pmodel_if.slave  bus
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW        = DATA_WIDTH / WMASK_WIDTH;
    localparam int CNT_W     = ADDR_WIDTH + 1;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic   RESET_BUSY  = (CLEAR_ON_RESET != 0);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;

    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

    logic access;
    logic last_addr;

    assign access    = bus.ce && !busy_q;
    assign last_addr = (cnt_q == CNT_W'(RAM_DEPTH - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                // The wide counter plus last-address compare stops after exactly one pass.
                if (last_addr) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (access && !bus.we) begin
                    dout_d       = mem[bus.addr];
                    dout_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
                busy_d  = RESET_BUSY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            busy_q       <= RESET_BUSY;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Reset blocks both the sweep and any access sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rstb) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
            end else if (access && bus.we) begin
                for (int i = 0; i < WMASK_WIDTH; i++) begin
                    if (bus.wmask[i]) begin
                        mem[bus.addr][i*LW +: LW] <= bus.din[i*LW +: LW];
                    end
                end
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sram22_pmodel.sv
// Scoreboard bench for sram22_pmodel: default build, a no-clear build and a
// 24-bit / 3-lane / 64-word build, exercised one at a time against one model.
module tb_sram22_pmodel;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb_a = 1'b0;
    logic rstb_b = 1'b0;
    logic rstb_c = 1'b0;

    sram22_pmodel_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4)) if_a ();
    sram22_pmodel_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4)) if_b ();
    sram22_pmodel_if #(.DATA_WIDTH(24), .ADDR_WIDTH(6), .WMASK_WIDTH(3)) if_c ();

    sram22_pmodel #(.CLEAR_ON_RESET(1)) u_a (.clk(clk), .rstb(rstb_a), .bus(if_a.slave));
    sram22_pmodel #(.CLEAR_ON_RESET(0)) u_b (.clk(clk), .rstb(rstb_b), .bus(if_b.slave));
    sram22_pmodel #(.DATA_WIDTH(24), .ADDR_WIDTH(6), .WMASK_WIDTH(3), .CLEAR_ON_RESET(1))
        u_c (.clk(clk), .rstb(rstb_c), .bus(if_c.slave));

    int          cur     = 0;
    logic        t_ce    = 1'b0;
    logic        t_we    = 1'b0;
    logic [3:0]  t_wmask = '0;
    logic [7:0]  t_addr  = '0;
    logic [31:0] t_din   = '0;

    assign if_a.ce    = (cur == 0) && t_ce;
    assign if_a.we    = t_we;
    assign if_a.wmask = t_wmask;
    assign if_a.addr  = t_addr;
    assign if_a.din   = t_din;
    assign if_b.ce    = (cur == 1) && t_ce;
    assign if_b.we    = t_we;
    assign if_b.wmask = t_wmask;
    assign if_b.addr  = t_addr;
    assign if_b.din   = t_din;
    assign if_c.ce    = (cur == 2) && t_ce;
    assign if_c.we    = t_we;
    assign if_c.wmask = t_wmask[2:0];
    assign if_c.addr  = t_addr[5:0];
    assign if_c.din   = t_din[23:0];

    logic [31:0] obs_dout;
    logic        obs_vld;
    logic        obs_busy;

    always_comb begin
        obs_dout = if_a.dout;
        obs_vld  = if_a.dout_valid;
        obs_busy = if_a.busy;
        if (cur == 1) begin
            obs_dout = if_b.dout;
            obs_vld  = if_b.dout_valid;
            obs_busy = if_b.busy;
        end else if (cur == 2) begin
            obs_dout = {8'h00, if_c.dout};
            obs_vld  = if_c.dout_valid;
            obs_busy = if_c.busy;
        end
    end

    // Reference model of whichever build is currently selected.
    logic [31:0] m_mem [256];
    int          m_depth;
    int          m_lanes;
    bit          m_clear;
    int          m_sweep;
    logic [31:0] m_dmask;
    logic [31:0] m_dout;

    typedef struct {
        logic        vld;
        logic [31:0] dout;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst_n, input bit ce, input bit we,
                                 input logic [3:0] wm, input int a, input logic [31:0] d);
        exp_t        e;
        int          am;
        logic [31:0] dm;
        @(negedge clk);
        case (cur)
            0: rstb_a = rst_n;
            1: rstb_b = rst_n;
            default: rstb_c = rst_n;
        endcase
        t_ce    = ce;
        t_we    = we;
        t_wmask = wm;
        t_addr  = 8'(a);
        t_din   = d;
        am      = a % m_depth;
        dm      = d & m_dmask;
        e.vld   = 1'b0;
        if (!rst_n) begin
            m_dout  = '0;
            m_sweep = m_clear ? m_depth : 0;
        end else if (m_sweep > 0) begin
            m_mem[m_depth - m_sweep] = '0;
            m_sweep--;
        end else if (ce) begin
            if (we) begin
                for (int i = 0; i < m_lanes; i++)
                    if (wm[i]) m_mem[am][i*8 +: 8] = dm[i*8 +: 8];
            end else begin
                m_dout = m_mem[am];
                e.vld  = 1'b1;
            end
        end
        e.dout = m_dout;
        e.busy = (m_sweep > 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput("dout_valid", {31'b0, obs_vld}, {31'b0, e.vld});
        checkOutput("dout", obs_dout, e.dout);
        checkOutput("busy", {31'b0, obs_busy}, {31'b0, e.busy});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 0, 32'h0);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] wm);
        applyStimulus(1'b1, 1'b1, 1'b1, wm, a, d);
    endtask

    task automatic rd(input int a);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask

    task automatic selectDut(input int which);
        cur     = which;
        m_depth = (which == 2) ? 64 : 256;
        m_lanes = (which == 2) ? 3 : 4;
        m_clear = (which != 1);
        m_dmask = (which == 2) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
        m_sweep = 0;
        m_dout  = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
    endtask

    initial begin
        // Default build: reset, sweep with ignored accesses, then basic traffic.
        selectDut(0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        wr(5, 32'h5555_5555, 4'hF);
        rd(5);
        idle(254);
        rd(8'h00);
        rd(8'h7F);
        rd(8'hFF);
        rd(5);
        wr(8'h10, 32'hDEAD_BEEF, 4'hF);
        wr(8'h10, 32'h1122_3344, 4'b0101);
        rd(8'h10);
        checkOutput("mask_merge", obs_dout, 32'hDE22_BE44);
        wr(8'h21, 32'hCAFE_F00D, 4'hF);
        wr(8'h20, 32'h0BAD_C0DE, 4'hF);
        rd(8'h20);
        rd(8'h21);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 8'h20, 32'h1234_5678);
        wr(8'h10, 32'hFFFF_FFFF, 4'h0);
        rd(8'h20);
        rd(8'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        idle(100);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        idle(256);
        rd(8'h10);
        rd(8'h20);

        // No-clear build: contents survive reset and a reset-edge write is dropped.
        selectDut(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        for (int i = 0; i < 256; i++) wr(i, 32'hFFFF_FFFF, 4'hF);
        idle(100);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 8'h33, 32'h0);
        idle(2);
        rd(8'h00);
        rd(8'h33);
        rd(8'hFF);
        checkOutput("retained", obs_dout, 32'hFFFF_FFFF);

        // Narrow build: 64-word sweep, then random traffic against the model.
        selectDut(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        idle(64);
        wr(3, 32'h00AA_BBCC, 3'b010);
        rd(3);
        checkOutput("lane1", obs_dout, 32'h0000_BB00);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b1, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 15)), $urandom_range(0, 63), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
